// File: rtl/pgm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pgm_pkg
// Description : Shared constants for the packet generator write/read sides.
// Revision    : 1.0 - initial release
// ============================================================================
package pgm_pkg;

    localparam int c_BEAT_W = 134;
    localparam int c_PHV_W  = 1024;

    localparam logic [1:0] c_HDR_HEAD = 2'b01;
    localparam logic [1:0] c_HDR_BODY = 2'b11;
    localparam logic [1:0] c_HDR_TAIL = 2'b10;

    localparam logic [2:0] c_OP_WRITE   = 3'b010;
    localparam logic [2:0] c_OP_READ    = 3'b001;
    localparam logic [3:0] c_REPLY_CODE = 4'b1011;

    localparam logic [31:0] c_REG_CTRL     = 32'h0;
    localparam logic [31:0] c_REG_GEN_TIME = 32'h1;
    localparam logic [31:0] c_REG_STATUS   = 32'h2;
    localparam logic [31:0] c_REG_TMPL_LEN = 32'h3;
    localparam logic [31:0] c_REG_TIMER    = 32'h4;

    localparam int         c_RAM_DEPTH = 128;
    localparam int         c_RAM_AW    = 7;
    localparam int         c_RAM_DW    = 144;
    localparam logic [6:0] c_RAM_LAST  = 7'd127;

    // A_PASS / A_DROP track the packet in flight while a template is armed
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PASS   = 3'd1;
    localparam logic [2:0] ST_STORE  = 3'd2;
    localparam logic [2:0] ST_ARMED  = 3'd3;
    localparam logic [2:0] ST_GEN    = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;
    localparam logic [2:0] ST_A_PASS = 3'd6;
    localparam logic [2:0] ST_A_DROP = 3'd7;

endpackage
`default_nettype wire

// File: rtl/pgm_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : pgm_cfg_regs
// Description : Cfg-chain decode, PGM control/status registers, read reply.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_cfg_regs
    import pgm_pkg::*;
#(
    parameter logic [7:0] LMID = 8'd60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_BEAT_W-1:0] cin_wr_data,
    input  logic                cin_wr_data_wr,
    output logic [c_BEAT_W-1:0] cout_wr_data,
    output logic                cout_wr_data_wr,
    input  logic [3:0]          status,
    input  logic [7:0]          tmpl_len,
    input  logic [31:0]         gen_timer,
    output logic                soft_rst,
    output logic                gen_start,
    output logic                gen_stop,
    output logic [31:0]         gen_time
);

    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_addr;
    logic [31:0] w_wval;
    logic [31:0] w_rval;
    logic [31:0] r_gen_time;

    assign w_hit  = cin_wr_data_wr && (cin_wr_data[133:132] == c_HDR_HEAD)
                    && (cin_wr_data[103:96] == LMID);
    assign w_wr   = w_hit && (cin_wr_data[126:124] == c_OP_WRITE);
    assign w_rd   = w_hit && (cin_wr_data[126:124] == c_OP_READ);
    assign w_addr = cin_wr_data[95:64];
    assign w_wval = cin_wr_data[31:0];

    // Control bits are pulses decoded straight off the cfg beat
    assign soft_rst  = w_wr && (w_addr == c_REG_CTRL) && w_wval[0];
    assign gen_start = w_wr && (w_addr == c_REG_CTRL) && w_wval[1];
    assign gen_stop  = w_wr && (w_addr == c_REG_CTRL) && w_wval[2];
    assign gen_time  = r_gen_time;

    always_comb begin
        w_rval = 32'hffff_ffff;
        case (w_addr)
            c_REG_CTRL:     w_rval = 32'h0;
            c_REG_GEN_TIME: w_rval = r_gen_time;
            c_REG_STATUS:   w_rval = {28'b0, status};
            c_REG_TMPL_LEN: w_rval = {24'b0, tmpl_len};
            c_REG_TIMER:    w_rval = gen_timer;
            default:        w_rval = 32'hffff_ffff;
        endcase
    end

    // The chain itself only follows rst so a soft-reset write still reaches cout
    always_ff @(posedge clk) begin
        if (rst) begin
            cout_wr_data    <= '0;
            cout_wr_data_wr <= 1'b0;
            r_gen_time      <= '0;
        end else begin
            cout_wr_data_wr <= cin_wr_data_wr;
            cout_wr_data    <= w_rd ? {cin_wr_data[133:128], c_REPLY_CODE,
                                       cin_wr_data[123:32], w_rval}
                                    : cin_wr_data;
            if (soft_rst)
                r_gen_time <= '0;
            else if (w_wr && (w_addr == c_REG_GEN_TIME))
                r_gen_time <= w_wval;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pgm_wr.sv
`default_nettype none
// ============================================================================
// Module      : pgm_wr
// Description : PGM write side - template capture, pass-through, gen control.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_wr
    import pgm_pkg::*;
#(
    parameter             PLATFORM = "Xilinx",
    parameter logic [7:0] LMID     = 8'd60,
    parameter logic [7:0] NMID     = 8'd61
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_PHV_W-1:0]  in_wr_phv,
    input  logic                in_wr_phv_wr,
    output logic                out_wr_phv_alf,
    input  logic [c_BEAT_W-1:0] in_wr_data,
    input  logic                in_wr_data_wr,
    input  logic                in_wr_valid,
    input  logic                in_wr_valid_wr,
    output logic                out_wr_alf,
    output logic [c_PHV_W-1:0]  out_wr_phv,
    output logic                out_wr_phv_wr,
    input  logic                in_wr_phv_alf,
    output logic [c_BEAT_W-1:0] out_wr_data,
    output logic                out_wr_data_wr,
    output logic                out_wr_valid,
    output logic                out_wr_valid_wr,
    input  logic                in_wr_alf,
    output logic                pgm_bypass_flag,
    output logic                pgm_sent_start_flag,
    output logic                pgm_sent_finish_flag,
    output logic                wr2ram_wr,
    output logic [c_RAM_AW-1:0] wr2ram_addr,
    output logic [c_RAM_DW-1:0] wr2ram_wdata,
    input  logic [c_BEAT_W-1:0] cin_wr_data,
    input  logic                cin_wr_data_wr,
    output logic                cout_wr_ready,
    output logic [c_BEAT_W-1:0] cout_wr_data,
    output logic                cout_wr_data_wr,
    input  logic                cin_wr_ready
);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [6:0]          r_wptr;
    logic [7:0]          r_tmpl_len;
    logic                r_stored;
    logic                r_overflow;
    logic [31:0]         r_timer;
    logic [31:0]         w_gen_time;
    logic                w_soft_rst;
    logic                w_start;
    logic                w_stop;
    logic                w_rst;
    logic                w_is_head;
    logic                w_is_tail;
    logic                w_is_tmpl;
    logic                w_fwd;
    logic                w_fwd_ok;
    logic                w_ram_we;
    logic                w_gen;
    logic                w_fin;
    logic [c_BEAT_W-1:0] w_ram_beat;
    logic                w_unused_params;

    assign w_unused_params = (PLATFORM == "Xilinx") ^ (^NMID);

    assign out_wr_phv_alf = in_wr_phv_alf;
    assign out_wr_alf     = in_wr_alf;
    assign cout_wr_ready  = cin_wr_ready;

    assign w_rst     = rst || w_soft_rst;
    assign w_is_head = in_wr_data_wr && (in_wr_data[133:132] == c_HDR_HEAD);
    assign w_is_tail = in_wr_data_wr && (in_wr_data[133:132] == c_HDR_TAIL);
    assign w_is_tmpl = w_is_head && (in_wr_data[103:96] == LMID);

    pgm_cfg_regs #(
        .LMID (LMID)
    ) u_cfg_regs (
        .clk             (clk),
        .rst             (rst),
        .cin_wr_data     (cin_wr_data),
        .cin_wr_data_wr  (cin_wr_data_wr),
        .cout_wr_data    (cout_wr_data),
        .cout_wr_data_wr (cout_wr_data_wr),
        .status          ({r_overflow, w_fin, w_gen, r_stored}),
        .tmpl_len        (r_tmpl_len),
        .gen_timer       (r_timer),
        .soft_rst        (w_soft_rst),
        .gen_start       (w_start),
        .gen_stop        (w_stop),
        .gen_time        (w_gen_time)
    );

    always_ff @(posedge clk) begin
        if (w_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_tmpl && !r_stored)
                    w_next = ST_STORE;
                else if (w_is_head && !w_is_tmpl)
                    w_next = ST_PASS;
            end
            ST_PASS:
                if (w_is_tail) w_next = ST_IDLE;
            ST_STORE: begin
                if (w_is_tail)
                    w_next = ST_ARMED;
                else if (in_wr_data_wr && (r_wptr == c_RAM_LAST))
                    w_next = ST_A_DROP;
            end
            ST_ARMED, ST_A_PASS, ST_A_DROP: begin
                // stop in the same write as start cancels the launch
                if (w_start && !w_stop)
                    w_next = ST_GEN;
                else if (r_state == ST_ARMED) begin
                    if (w_is_tmpl)
                        w_next = ST_A_DROP;
                    else if (w_is_head)
                        w_next = ST_A_PASS;
                end else if (w_is_tail)
                    w_next = ST_ARMED;
            end
            ST_GEN: begin
                if (w_stop || ((w_gen_time != 32'd0) && (r_timer == w_gen_time - 32'd1)))
                    w_next = ST_FIN;
            end
            ST_FIN:
                w_next = ST_FIN;
            default:
                w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fwd      = 1'b0;
        w_fwd_ok   = 1'b0;
        w_ram_we   = 1'b0;
        w_gen      = 1'b0;
        w_fin      = 1'b0;
        w_ram_beat = in_wr_data;
        case (r_state)
            ST_IDLE: begin
                w_fwd_ok = 1'b1;
                w_fwd    = w_is_head && !w_is_tmpl;
                w_ram_we = w_is_tmpl && !r_stored;
            end
            ST_PASS, ST_A_PASS: begin
                w_fwd_ok = 1'b1;
                w_fwd    = in_wr_data_wr;
            end
            ST_STORE: begin
                w_ram_we = in_wr_data_wr;
                // last RAM slot is forced to a tail so the stored packet stays closed
                if ((r_wptr == c_RAM_LAST) && (in_wr_data[133:132] != c_HDR_TAIL))
                    w_ram_beat[133:132] = c_HDR_TAIL;
            end
            ST_ARMED: begin
                w_fwd_ok = 1'b1;
                w_fwd    = w_is_head && !w_is_tmpl;
            end
            ST_GEN: w_gen = 1'b1;
            ST_FIN: w_fin = 1'b1;
            default: ;
        endcase
    end

    assign pgm_bypass_flag      = !(w_gen || w_fin);
    assign pgm_sent_start_flag  = w_gen;
    assign pgm_sent_finish_flag = w_fin;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            out_wr_data     <= '0;
            out_wr_data_wr  <= 1'b0;
            out_wr_valid    <= 1'b0;
            out_wr_valid_wr <= 1'b0;
            out_wr_phv      <= '0;
            out_wr_phv_wr   <= 1'b0;
            wr2ram_wr       <= 1'b0;
            wr2ram_addr     <= '0;
            wr2ram_wdata    <= '0;
            r_wptr          <= '0;
            r_tmpl_len      <= '0;
            r_stored        <= 1'b0;
            r_overflow      <= 1'b0;
            r_timer         <= '0;
        end else begin
            out_wr_data     <= in_wr_data;
            out_wr_data_wr  <= w_fwd;
            out_wr_valid    <= in_wr_valid;
            out_wr_valid_wr <= in_wr_valid_wr && w_fwd_ok;
            out_wr_phv      <= in_wr_phv;
            out_wr_phv_wr   <= in_wr_phv_wr && !(w_gen || w_fin);
            wr2ram_wr       <= w_ram_we;
            if (w_ram_we) begin
                wr2ram_addr  <= (r_state == ST_STORE) ? r_wptr : 7'd0;
                wr2ram_wdata <= {10'b0, w_ram_beat};
                r_wptr       <= (r_state == ST_STORE) ? r_wptr + 7'd1 : 7'd1;
            end
            // length is 8 bits wide so a full 128-beat template reads back correctly
            if ((r_state == ST_STORE) && in_wr_data_wr) begin
                if (w_is_tail) begin
                    r_stored   <= 1'b1;
                    r_tmpl_len <= {1'b0, r_wptr} + 8'd1;
                end else if (r_wptr == c_RAM_LAST) begin
                    r_stored   <= 1'b1;
                    r_overflow <= 1'b1;
                    r_tmpl_len <= 8'd128;
                end
            end
            if ((r_state != ST_GEN) && (w_next == ST_GEN))
                r_timer <= '0;
            else if ((r_state == ST_GEN) && (w_next == ST_GEN))
                r_timer <= r_timer + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pgm_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_pgm_wr
// Description : Directed self-checking bench for pgm_wr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pgm_wr;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] in_wr_phv;
    logic          in_wr_phv_wr;
    logic          out_wr_phv_alf;
    logic [133:0]  in_wr_data;
    logic          in_wr_data_wr;
    logic          in_wr_valid;
    logic          in_wr_valid_wr;
    logic          out_wr_alf;
    logic [1023:0] out_wr_phv;
    logic          out_wr_phv_wr;
    logic          in_wr_phv_alf;
    logic [133:0]  out_wr_data;
    logic          out_wr_data_wr;
    logic          out_wr_valid;
    logic          out_wr_valid_wr;
    logic          in_wr_alf;
    logic          pgm_bypass_flag;
    logic          pgm_sent_start_flag;
    logic          pgm_sent_finish_flag;
    logic          wr2ram_wr;
    logic [6:0]    wr2ram_addr;
    logic [143:0]  wr2ram_wdata;
    logic [133:0]  cin_wr_data;
    logic          cin_wr_data_wr;
    logic          cout_wr_ready;
    logic [133:0]  cout_wr_data;
    logic          cout_wr_data_wr;
    logic          cin_wr_ready;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pgm_wr #(
        .PLATFORM ("Xilinx"),
        .LMID     (8'd60),
        .NMID     (8'd61)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_wr_phv            (in_wr_phv),
        .in_wr_phv_wr         (in_wr_phv_wr),
        .out_wr_phv_alf       (out_wr_phv_alf),
        .in_wr_data           (in_wr_data),
        .in_wr_data_wr        (in_wr_data_wr),
        .in_wr_valid          (in_wr_valid),
        .in_wr_valid_wr       (in_wr_valid_wr),
        .out_wr_alf           (out_wr_alf),
        .out_wr_phv           (out_wr_phv),
        .out_wr_phv_wr        (out_wr_phv_wr),
        .in_wr_phv_alf        (in_wr_phv_alf),
        .out_wr_data          (out_wr_data),
        .out_wr_data_wr       (out_wr_data_wr),
        .out_wr_valid         (out_wr_valid),
        .out_wr_valid_wr      (out_wr_valid_wr),
        .in_wr_alf            (in_wr_alf),
        .pgm_bypass_flag      (pgm_bypass_flag),
        .pgm_sent_start_flag  (pgm_sent_start_flag),
        .pgm_sent_finish_flag (pgm_sent_finish_flag),
        .wr2ram_wr            (wr2ram_wr),
        .wr2ram_addr          (wr2ram_addr),
        .wr2ram_wdata         (wr2ram_wdata),
        .cin_wr_data          (cin_wr_data),
        .cin_wr_data_wr       (cin_wr_data_wr),
        .cout_wr_ready        (cout_wr_ready),
        .cout_wr_data         (cout_wr_data),
        .cout_wr_data_wr      (cout_wr_data_wr),
        .cin_wr_ready         (cin_wr_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] dbeat(input logic [1:0] hdr, input logic [7:0] mid,
                                           input logic [31:0] pay);
        logic [133:0] b;
        b          = '0;
        b[133:132] = hdr;
        b[103:96]  = mid;
        b[63:32]   = pay ^ 32'ha5a5_a5a5;
        b[31:0]    = pay;
        return b;
    endfunction

    function automatic logic [133:0] cbeat(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] val);
        logic [133:0] b;
        b          = '0;
        b[133:132] = 2'b01;
        b[126:124] = op;
        b[103:96]  = 8'd60;
        b[95:64]   = addr;
        b[31:0]    = val;
        return b;
    endfunction

    task automatic send(input logic [133:0] b);
        in_wr_data    = b;
        in_wr_data_wr = 1'b1;
        tick();
        in_wr_data_wr = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] val);
        logic [133:0] b;
        b              = cbeat(3'b010, addr, val);
        cin_wr_data    = b;
        cin_wr_data_wr = 1'b1;
        tick();
        cin_wr_data_wr = 1'b0;
        chk("cfg_write_passthru", {10'b0, cout_wr_data}, {10'b0, b});
    endtask

    task automatic cfg_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cin_wr_data    = cbeat(3'b001, addr, 32'h0);
        cin_wr_data_wr = 1'b1;
        tick();
        cin_wr_data_wr = 1'b0;
        chk({tag, "_strobe"}, cout_wr_data_wr, 1'b1);
        chk({tag, "_code"}, cout_wr_data[127:124], 4'b1011);
        chk(tag, cout_wr_data[31:0], exp);
    endtask

    initial begin
        logic [133:0] b;
        int           nw;
        int           nf;
        logic [1:0]   h127;

        rst = 1'b1;
        in_wr_phv = '0; in_wr_phv_wr = 1'b0; in_wr_phv_alf = 1'b0;
        in_wr_data = '0; in_wr_data_wr = 1'b0;
        in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0; in_wr_alf = 1'b0;
        cin_wr_data = '0; cin_wr_data_wr = 1'b0; cin_wr_ready = 1'b0;
        tick();
        tick();
        chk("rst_bypass", pgm_bypass_flag, 1'b1);
        chk("rst_start", pgm_sent_start_flag, 1'b0);
        chk("rst_finish", pgm_sent_finish_flag, 1'b0);
        chk("rst_data_wr", out_wr_data_wr, 1'b0);
        chk("rst_ram_wr", wr2ram_wr, 1'b0);
        chk("rst_cout_wr", cout_wr_data_wr, 1'b0);
        rst = 1'b0;
        in_wr_alf = 1'b1; cin_wr_ready = 1'b1;
        #1;
        chk("alf_follow", out_wr_alf, 1'b1);
        chk("ready_follow", cout_wr_ready, 1'b1);
        tick();

        // non-template packet forwarded with one cycle of latency
        for (int i = 0; i < 3; i++) begin
            b = dbeat((i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'b10, 8'h10, 32'h100 + i);
            send(b);
            chk("pass_wr", out_wr_data_wr, 1'b1);
            chk("pass_data", {10'b0, out_wr_data}, {10'b0, b});
            chk("pass_no_ram", wr2ram_wr, 1'b0);
        end
        tick();
        chk("pass_idle", out_wr_data_wr, 1'b0);

        // 4-beat template into RAM at 0..3, nothing forwarded
        for (int i = 0; i < 4; i++) begin
            b = dbeat((i == 0) ? 2'b01 : (i == 3) ? 2'b10 : 2'b11, (i == 0) ? 8'd60 : 8'h00, 32'h200 + i);
            send(b);
            chk("tmpl_ram_wr", wr2ram_wr, 1'b1);
            chk("tmpl_ram_addr", wr2ram_addr, i[6:0]);
            chk("tmpl_ram_data", wr2ram_wdata, {10'b0, b});
            chk("tmpl_no_fwd", out_wr_data_wr, 1'b0);
        end
        cfg_read("status_stored", 32'h2, 32'h1);
        cfg_read("tmpl_len_4", 32'h3, 32'h4);

        // pass-through while armed
        b = dbeat(2'b01, 8'h22, 32'h300);
        send(b);
        chk("armed_pass", out_wr_data_wr, 1'b1);
        send(dbeat(2'b10, 8'h00, 32'h301));
        chk("armed_pass_tail", out_wr_data_wr, 1'b1);

        // timed generation: 100 cycles of start
        cfg_write(32'h1, 32'd100);
        cfg_read("gen_time_rd", 32'h1, 32'd100);
        cfg_write(32'h0, 32'h2);
        chk("gen_bypass", pgm_bypass_flag, 1'b0);
        chk("gen_start", pgm_sent_start_flag, 1'b1);
        send(dbeat(2'b01, 8'h10, 32'h400));
        chk("gen_drop", out_wr_data_wr, 1'b0);
        for (int i = 0; i < 98; i++) tick();
        chk("gen_start_99", pgm_sent_start_flag, 1'b1);
        chk("gen_finish_99", pgm_sent_finish_flag, 1'b0);
        tick();
        chk("fin_finish", pgm_sent_finish_flag, 1'b1);
        chk("fin_start", pgm_sent_start_flag, 1'b0);
        chk("fin_bypass", pgm_bypass_flag, 1'b0);
        cfg_read("fin_timer", 32'h4, 32'd99);
        cfg_read("fin_status", 32'h2, 32'h5);

        cfg_write(32'h0, 32'h1);
        chk("srst_bypass", pgm_bypass_flag, 1'b1);
        chk("srst_finish", pgm_sent_finish_flag, 1'b0);
        cfg_read("srst_status", 32'h2, 32'h0);
        cfg_read("srst_gen_time", 32'h1, 32'h0);

        // stop-only runs, start+stop together does nothing
        send(dbeat(2'b01, 8'd60, 32'h500));
        send(dbeat(2'b10, 8'h00, 32'h501));
        cfg_read("tmpl2_len", 32'h3, 32'h2);
        cfg_write(32'h0, 32'h6);
        chk("startstop_start", pgm_sent_start_flag, 1'b0);
        chk("startstop_bypass", pgm_bypass_flag, 1'b1);
        cfg_write(32'h0, 32'h2);
        chk("stop_gen_start", pgm_sent_start_flag, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        chk("stop_gen_running", pgm_sent_start_flag, 1'b1);
        cfg_write(32'h0, 32'h4);
        chk("stop_finish", pgm_sent_finish_flag, 1'b1);
        chk("stop_start", pgm_sent_start_flag, 1'b0);
        cfg_read("stop_timer", 32'h4, 32'd9);
        cfg_write(32'h0, 32'h1);

        // 130-beat template overflows the RAM
        nw = 0; nf = 0; h127 = 2'b00;
        for (int i = 0; i < 130; i++) begin
            send(dbeat((i == 0) ? 2'b01 : (i == 129) ? 2'b10 : 2'b11, (i == 0) ? 8'd60 : 8'h00, i));
            if (wr2ram_wr) begin
                nw++;
                if (wr2ram_addr == 7'd127) h127 = wr2ram_wdata[133:132];
            end
            if (out_wr_data_wr) nf++;
        end
        chk("ovf_writes", nw, 128);
        chk("ovf_hdr127", h127, 2'b10);
        chk("ovf_no_fwd", nf, 0);
        cfg_read("ovf_status", 32'h2, 32'h9);
        send(dbeat(2'b01, 8'h33, 32'h600));
        chk("ovf_armed_pass", out_wr_data_wr, 1'b1);
        send(dbeat(2'b10, 8'h00, 32'h601));

        // unknown register address
        cin_wr_data    = cbeat(3'b001, 32'h7, 32'h0);
        cin_wr_data_wr = 1'b1;
        tick();
        cin_wr_data_wr = 1'b0;
        chk("rd7_value", cout_wr_data[31:0], 32'hffff_ffff);
        chk("rd7_code", cout_wr_data[127:124], 4'b1011);
        chk("rd7_hdr", cout_wr_data[133:128], 6'b010000);

        // hard reset in the middle of a template capture
        cfg_write(32'h0, 32'h1);
        send(dbeat(2'b01, 8'd60, 32'h700));
        send(dbeat(2'b11, 8'h00, 32'h701));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_read("rst_mid_status", 32'h2, 32'h0);
        send(dbeat(2'b01, 8'd60, 32'h800));
        chk("retmpl_wr", wr2ram_wr, 1'b1);
        chk("retmpl_addr", wr2ram_addr, 7'd0);
        send(dbeat(2'b10, 8'h00, 32'h801));
        chk("retmpl_addr1", wr2ram_addr, 7'd1);
        cfg_read("retmpl_status", 32'h2, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
